// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - parametrised register file with write bypass and busy scoreboard
// Out-of-range read addresses return the immediate; stall flags reads/claims of pending results.
module regfile_sb #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 7,
  parameter int BYPASS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [ADDR_W-1:0]      rd_addr_a,
  input  logic [ADDR_W-1:0]      rd_addr_b,
  input  logic [WIDTH-1:0]       imm,
  input  logic                   claim_en,
  input  logic [ADDR_W-1:0]      claim_addr,
  output logic [WIDTH-1:0]       rd_data_a,
  output logic [WIDTH-1:0]       rd_data_b,
  output logic                   stall,
  output logic [NREGS-1:0]       busy,
  output logic [NREGS*WIDTH-1:0] regs_flat
);

  localparam logic              LP_BYP   = (BYPASS != 0);
  localparam logic [ADDR_W:0]   LP_NREGS = (ADDR_W+1)'(NREGS);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic [WIDTH-1:0] w_stored_a, w_stored_b;
  logic             w_busy_a, w_busy_b, w_busy_c;
  logic             w_in_a, w_in_b, w_in_c, w_in_w;
  logic             w_byp_a, w_byp_b;
  logic             w_hit_a, w_hit_b, w_waw;
  logic             w_wr_fire, w_claim_fire;

  // Lookups only cover implemented registers, so out-of-range addresses see 0/not-busy.
  always_comb begin
    w_stored_a = '0;
    w_stored_b = '0;
    w_busy_a   = 1'b0;
    w_busy_b   = 1'b0;
    w_busy_c   = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (rd_addr_a == ADDR_W'(i)) begin
        w_stored_a = r_regs[i];
        w_busy_a   = r_busy[i];
      end
      if (rd_addr_b == ADDR_W'(i)) begin
        w_stored_b = r_regs[i];
        w_busy_b   = r_busy[i];
      end
      if (claim_addr == ADDR_W'(i)) w_busy_c = r_busy[i];
    end
  end

  assign w_in_a = ({1'b0, rd_addr_a}  < LP_NREGS);
  assign w_in_b = ({1'b0, rd_addr_b}  < LP_NREGS);
  assign w_in_c = ({1'b0, claim_addr} < LP_NREGS);
  assign w_in_w = ({1'b0, wr_addr}    < LP_NREGS);

  assign w_byp_a = LP_BYP && wr_en && (wr_addr == rd_addr_a);
  assign w_byp_b = LP_BYP && wr_en && (wr_addr == rd_addr_b);

  assign rd_data_a = !w_in_a ? imm : (w_byp_a ? wr_data : w_stored_a);
  assign rd_data_b = !w_in_b ? imm : (w_byp_b ? wr_data : w_stored_b);

  assign w_hit_a = w_in_a && w_busy_a && !w_byp_a;
  assign w_hit_b = w_in_b && w_busy_b && !w_byp_b;
  assign w_waw   = claim_en && w_in_c && w_busy_c && !(wr_en && (wr_addr == claim_addr));
  assign stall   = w_hit_a || w_hit_b || w_waw;

  assign w_wr_fire    = wr_en && w_in_w;
  assign w_claim_fire = claim_en && w_in_c && !stall;

  // A claim beats a same-register write on busy: it names a newer in-flight result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_fire && (wr_addr == ADDR_W'(i))) r_regs[i] <= wr_data;
        if (w_claim_fire && (claim_addr == ADDR_W'(i)))
          r_busy[i] <= 1'b1;
        else if (w_wr_fire && (wr_addr == ADDR_W'(i)))
          r_busy[i] <= 1'b0;
      end
    end
  end

  assign busy = r_busy;

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = r_regs[g];
  end

endmodule
